// File: rtl/servisia_sram_pkg.sv
// Shared types for the servisia SRAM controller.
// FSM state encoding and wait-counter sizing.
package servisia_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_TA,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } sram_state_e;

    function automatic int cnt_width(input int rd_wait, input int wr_pulse);
        int m;
        m = (rd_wait > wr_pulse) ? rd_wait : wr_pulse;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/servisia_sram_ctrl.sv
// Byte-wide async SRAM controller for the servisia memory port.
// Registered strobes, programmable read wait and write pulse width.
module servisia_sram_ctrl
    import servisia_sram_pkg::*;
#(
    parameter int ADDR_WIDTH      = 20,
    parameter int DATA_WIDTH      = 8,
    parameter int RD_WAIT_CYCLES  = 2,
    parameter int WR_PULSE_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_cs_n_o,
    output logic                  sram_we_n_o,
    output logic                  sram_oe_n_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_dq_o,
    output logic                  sram_dq_oe_o,
    input  logic [DATA_WIDTH-1:0] sram_dq_i
);

    localparam int CW = cnt_width(RD_WAIT_CYCLES, WR_PULSE_CYCLES);
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_PULSE_CYCLES - 1);

    sram_state_e   state;
    logic [CW-1:0] cnt;

    assign req_ready_o = (state == ST_IDLE) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            sram_cs_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_dq_oe_o <= 1'b0;
            sram_addr_o  <= '0;
            sram_dq_o    <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        sram_addr_o <= req_addr_i;
                        sram_cs_n_o <= 1'b0;
                        if (req_we_i) begin
                            sram_dq_o    <= req_wdata_i;
                            sram_dq_oe_o <= 1'b1;
                            state        <= ST_WR_SETUP;
                        end else begin
                            sram_oe_n_o <= 1'b0;
                            cnt         <= RD_LOAD;
                            state       <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    // Sample DQ on the final OE cycle, then release the bus.
                    if (cnt == '0) begin
                        rsp_rdata_o <= sram_dq_i;
                        rsp_valid_o <= 1'b1;
                        sram_cs_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        state       <= ST_TA;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_TA: begin
                    state <= ST_IDLE;
                end
                ST_WR_SETUP: begin
                    sram_we_n_o <= 1'b0;
                    cnt         <= WR_LOAD;
                    state       <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (cnt == '0) begin
                        sram_we_n_o <= 1'b1;
                        state       <= ST_WR_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_WR_HOLD: begin
                    sram_cs_n_o  <= 1'b1;
                    sram_dq_oe_o <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servisia_sram_ctrl.sv
// Bench for servisia_sram_ctrl: three parameter sets, board SRAM model,
// transaction-level reference model compared every cycle.
module tb_servisia_sram_ctrl;

    localparam int N  = 3;
    localparam int AW = 20;
    localparam int DW = 8;

    function automatic int rdw(input int k);
        return (k == 1) ? 1 : (k == 2) ? 4 : 2;
    endfunction

    function automatic int wrp(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst       [N];
    logic          req_valid [N];
    logic          req_we    [N];
    logic [AW-1:0] req_addr  [N];
    logic [DW-1:0] req_wdata [N];
    logic          req_ready [N];
    logic          rsp_valid [N];
    logic [DW-1:0] rsp_rdata [N];
    logic          cs_n      [N];
    logic          we_n      [N];
    logic          oe_n      [N];
    logic          dq_oe     [N];
    logic [AW-1:0] sram_addr [N];
    logic [DW-1:0] dq_o      [N];
    logic [DW-1:0] dq_i      [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        servisia_sram_ctrl #(
            .ADDR_WIDTH     (AW),
            .DATA_WIDTH     (DW),
            .RD_WAIT_CYCLES (rdw(g)),
            .WR_PULSE_CYCLES(wrp(g))
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst[g]),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_we_i    (req_we[g]),
            .req_addr_i  (req_addr[g]),
            .req_wdata_i (req_wdata[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_rdata_o (rsp_rdata[g]),
            .sram_cs_n_o (cs_n[g]),
            .sram_we_n_o (we_n[g]),
            .sram_oe_n_o (oe_n[g]),
            .sram_addr_o (sram_addr[g]),
            .sram_dq_o   (dq_o[g]),
            .sram_dq_oe_o(dq_oe[g]),
            .sram_dq_i   (dq_i[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit started  = 1'b0;

    // board SRAM contents and reference contents, keyed by instance+address
    logic [DW-1:0] mem     [int];
    logic [DW-1:0] exp_mem [int];

    // reference model: current transaction per instance (0 none, 1 rd, 2 wr)
    int            tx_kind  [N];
    int            tx_start [N];
    int            free_at  [N];
    logic [AW-1:0] tx_addr  [N];
    logic [AW-1:0] e_addr   [N];
    logic [DW-1:0] e_dq     [N];
    logic [DW-1:0] e_rd     [N];
    bit            rd_known [N];

    int   last_rsp  [N];
    int   rsp_cnt   [N];
    int   last_dqoe [N];
    int   oe_fall   [N];
    int   we_first  [N];
    int   we_last   [N];
    bit   pre_ok    [N];
    bit   post_ok   [N];
    logic prev_cs   [N];
    logic prev_we   [N];
    logic prev_oe   [N];
    logic prev_dqoe [N];
    logic [DW-1:0] rsp_log [$];

    function automatic int key(input int k, input logic [AW-1:0] a);
        return (k << AW) | int'(a);
    endfunction

    function automatic void chk(input string name, input int k,
                                input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s[%0d]: got %0h required %0h", name, k, act, req);
    endfunction

    function automatic logic [DW-1:0] mem_rd(input int k, input logic [AW-1:0] a);
        if (mem.exists(key(k, a)) != 0) return mem[key(k, a)];
        return DW'($urandom);
    endfunction

    task automatic sram_model(input int k);
        if (cs_n[k] === 1'b0 && we_n[k] === 1'b0 && dq_oe[k] === 1'b1)
            mem[key(k, sram_addr[k])] = dq_o[k];
        if (cs_n[k] === 1'b0 && oe_n[k] === 1'b0)
            dq_i[k] = mem_rd(k, sram_addr[k]);
        else
            dq_i[k] = DW'($urandom);
    endtask

    task automatic check_cycle(input int k);
        int n;
        int d;
        logic e_rdy, e_cs, e_we, e_oe, e_dqoe, e_rsp, inv;
        logic [DW-1:0] m_rd;
        n = cyc;
        d = n - tx_start[k];
        e_cs = 1'b1; e_we = 1'b1; e_oe = 1'b1; e_dqoe = 1'b0; e_rsp = 1'b0;
        if (tx_kind[k] == 1) begin
            if (d >= 1 && d <= rdw(k)) begin e_cs = 1'b0; e_oe = 1'b0; end
            if (d == rdw(k) + 1) e_rsp = 1'b1;
        end else if (tx_kind[k] == 2) begin
            if (d >= 1 && d <= wrp(k) + 2) begin e_cs = 1'b0; e_dqoe = 1'b1; end
            if (d >= 2 && d <= wrp(k) + 1) e_we = 1'b0;
        end
        e_rdy = !rst[k] && n >= free_at[k];
        m_rd = rd_known[k] ? rsp_rdata[k] : '0;
        chk("outputs", k,
            64'({e_rdy, e_cs, e_we, e_oe, e_dqoe, e_rsp, e_addr[k], e_dq[k],
                 rd_known[k] ? e_rd[k] : 8'h00}),
            64'({req_ready[k], cs_n[k], we_n[k], oe_n[k], dq_oe[k], rsp_valid[k],
                 sram_addr[k], dq_o[k], m_rd}));
        inv = !(!oe_n[k] && dq_oe[k]) && !(!oe_n[k] && !we_n[k]) &&
              (we_n[k] || (!cs_n[k] && dq_oe[k]));
        n_checks++;
        assert (inv === 1'b1) n_pass++;
        else $display("FAIL invariant[%0d]: got cs_n=%b we_n=%b oe_n=%b dq_oe=%b required no contention",
                      k, cs_n[k], we_n[k], oe_n[k], dq_oe[k]);
    endtask

    task automatic monitor(input int k);
        int n;
        n = cyc;
        if (we_n[k] === 1'b0 && prev_we[k] === 1'b1) begin
            we_first[k] = n;
            pre_ok[k] = (prev_cs[k] === 1'b0 && prev_dqoe[k] === 1'b1);
        end
        if (we_n[k] === 1'b0) we_last[k] = n;
        if (we_n[k] === 1'b1 && prev_we[k] === 1'b0)
            post_ok[k] = (cs_n[k] === 1'b0 && dq_oe[k] === 1'b1);
        if (dq_oe[k] === 1'b1) last_dqoe[k] = n;
        if (oe_n[k] === 1'b0 && prev_oe[k] === 1'b1) oe_fall[k] = n;
        if (rsp_valid[k] === 1'b1) begin
            last_rsp[k] = n;
            rsp_cnt[k]++;
            if (k == 0) rsp_log.push_back(rsp_rdata[k]);
        end
        prev_cs[k] = cs_n[k]; prev_we[k] = we_n[k];
        prev_oe[k] = oe_n[k]; prev_dqoe[k] = dq_oe[k];
    endtask

    // advances the reference across the clock edge that ends the current cycle
    task automatic model_edge(input int k);
        int n;
        n = cyc;
        if (rst[k]) begin
            if (tx_kind[k] == 2 && n < tx_start[k] + wrp(k) + 2)
                exp_mem.delete(key(k, tx_addr[k]));
            tx_kind[k] = 0;
            free_at[k] = n + 1;
            e_addr[k] = '0; e_dq[k] = '0; e_rd[k] = '0;
            rd_known[k] = 1'b1;
        end else begin
            if (tx_kind[k] == 1 && n == tx_start[k] + rdw(k)) begin
                rd_known[k] = (exp_mem.exists(key(k, tx_addr[k])) != 0);
                if (rd_known[k]) e_rd[k] = exp_mem[key(k, tx_addr[k])];
            end
            if (req_valid[k] && n >= free_at[k]) begin
                tx_start[k] = n;
                tx_addr[k] = req_addr[k];
                e_addr[k] = req_addr[k];
                if (req_we[k]) begin
                    tx_kind[k] = 2;
                    e_dq[k] = req_wdata[k];
                    exp_mem[key(k, req_addr[k])] = req_wdata[k];
                    free_at[k] = n + wrp(k) + 3;
                end else begin
                    tx_kind[k] = 1;
                    free_at[k] = n + rdw(k) + 2;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (started) begin
                check_cycle(k);
                monitor(k);
            end
            sram_model(k);
            model_edge(k);
        end
        started = 1'b1;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int c);
        repeat (c) step();
    endtask

    task automatic do_req(input int k, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int acc);
        bit done;
        done = 1'b0;
        acc = -1000;
        req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_valid[k] = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = (req_ready[k] === 1'b1);
            step();
        end
        req_valid[k] = 1'b0;
        if (done) acc = cyc - 1;
        else chk("req_timeout", k, 64'd0, 64'd1);
    endtask

    task automatic rd_check(input int k, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int lat);
        int acc;
        do_req(k, 1'b0, a, '0, acc);
        idle(rdw(k) + 3);
        chk("rd_latency", k, 64'(last_rsp[k] - acc), 64'(lat));
        chk("rd_data", k, 64'(rsp_rdata[k]), 64'(d));
    endtask

    task automatic wr_check(input int k, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int pulse);
        int acc;
        pre_ok[k] = 1'b0; post_ok[k] = 1'b0;
        we_first[k] = -100; we_last[k] = -200;
        do_req(k, 1'b1, a, d, acc);
        idle(wrp(k) + 3);
        chk("we_low_cycles", k, 64'(we_last[k] - we_first[k] + 1), 64'(pulse));
        chk("we_setup_delay", k, 64'(we_first[k] - acc), 64'd2);
        chk("wr_setup_hold", k, 64'({pre_ok[k], post_ok[k]}), 64'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, a0, a1, a2, c0;
        logic [AW-1:0] addrs [8];
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        addrs = '{20'h00000, 20'h00001, 20'h00002, 20'h00003,
                  20'h00010, 20'h00020, 20'hFFFFF, 20'h7FFFF};
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b1; req_we[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0;
            for (int i = 0; i < 8; i++) begin
                v = DW'($urandom);
                mem[key(k, addrs[i])] = v;
                exp_mem[key(k, addrs[i])] = v;
            end
        end
        mem[key(0, 20'h00000)] = 8'h11; exp_mem[key(0, 20'h00000)] = 8'h11;
        mem[key(0, 20'h00001)] = 8'h22; exp_mem[key(0, 20'h00001)] = 8'h22;
        mem[key(0, 20'hFFFFF)] = 8'h33; exp_mem[key(0, 20'hFFFFF)] = 8'h33;

        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 0, 64'(req_ready[0]), 64'd0);
            chk("rst_strobes", 0, 64'({cs_n[0], we_n[0], oe_n[0], dq_oe[0]}), 64'hE);
        end
        step();
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b0; req_valid[k] = 1'b0;
        end
        @(negedge clk);
        chk("ready_after_rst", 0, 64'(req_ready[0]), 64'd1);
        step();

        wr_check(0, 20'h00010, 8'hA5, 1);
        rd_check(0, 20'h00010, 8'hA5, 3);

        rsp_log.delete();
        do_req(0, 1'b0, 20'h00000, '0, a0);
        do_req(0, 1'b0, 20'h00001, '0, a1);
        do_req(0, 1'b0, 20'hFFFFF, '0, a2);
        idle(6);
        chk("b2b_spacing1", 0, 64'(a1 - a0), 64'd4);
        chk("b2b_spacing2", 0, 64'(a2 - a1), 64'd4);
        chk("b2b_count", 0, 64'(rsp_log.size()), 64'd3);
        if (rsp_log.size() >= 3)
            chk("b2b_data", 0, 64'({rsp_log[0], rsp_log[1], rsp_log[2]}), 64'h112233);

        wr_check(1, 20'h00040, 8'h3C, 3);
        rd_check(1, 20'h00040, 8'h3C, 2);
        wr_check(2, 20'h00041, 8'hC3, 3);
        rd_check(2, 20'h00041, 8'hC3, 5);

        do_req(0, 1'b1, 20'h00020, 8'h5A, acc);
        do_req(0, 1'b0, 20'h00020, '0, acc);
        idle(5);
        chk("turnaround", 0, 64'((oe_fall[0] - last_dqoe[0]) >= 2), 64'd1);
        chk("raw_data", 0, 64'(rsp_rdata[0]), 64'h5A);

        c0 = rsp_cnt[0];
        do_req(0, 1'b0, 20'h00001, '0, acc);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        @(negedge clk);
        chk("rd_abort_strobes", 0, 64'({cs_n[0], we_n[0], oe_n[0], dq_oe[0]}), 64'hE);
        step();
        idle(6);
        chk("rd_abort_no_rsp", 0, 64'(rsp_cnt[0] - c0), 64'd0);
        rd_check(0, 20'h00001, 8'h22, 3);

        do_req(1, 1'b1, 20'h00050, 8'h77, acc);
        step();
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        @(negedge clk);
        chk("wr_abort_strobes", 1, 64'({cs_n[1], we_n[1], oe_n[1], dq_oe[1]}), 64'hE);
        step();
        wr_check(1, 20'h00050, 8'h78, 3);
        rd_check(1, 20'h00050, 8'h78, 2);

        for (int k = 0; k < N; k++) begin
            repeat (60) begin
                a = addrs[$urandom_range(0, 7)];
                idle($urandom_range(0, 2));
                do_req(k, 1'($urandom_range(0, 1)), a, DW'($urandom), acc);
                if ($urandom_range(0, 15) == 0) begin
                    idle($urandom_range(0, 3));
                    rst[k] = 1'b1;
                    step();
                    rst[k] = 1'b0;
                end
            end
            idle(10);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
